// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//   Multiply uses shift-add, divide uses restoring shift-subtract on operand
//   magnitudes; signs are applied when the result is registered.
//   Optional macro FAST_MUL_EN: multiplies finish in the capture cycle using a
//   synthesised multiplier; divides remain iterative.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req                 valid M-extension op present in EX
//   funct3              0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1_val, rs2_val    forwarded operands
//   ack                 op leaves EX this cycle
//   flush               abort the current op
//   result              op result, valid while done=1
//   done                result valid, held until ack
//   busy                iterating
//   stall               req && !done, holds the upstream pipeline
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            ack,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;    // product/quotient is negated
  logic            r_rneg;   // remainder is negated (sign of rs1)
  logic [XLEN-1:0] r_a;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_hi;     // product high half or partial remainder
  logic [XLEN-1:0] r_lo;     // multiplier / dividend, shifted out as result bits enter
  logic [XLEN-1:0] r_result;
  logic            r_done;
  logic            r_busy;

  logic [1:0]       w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [2:0]       w_f3_n;
  logic             w_neg_n;
  logic             w_rneg_n;
  logic [XLEN-1:0]  w_a_n;
  logic [XLEN-1:0]  w_hi_n;
  logic [XLEN-1:0]  w_lo_n;
  logic [XLEN-1:0]  w_result_n;
  logic             w_done_n;
  logic             w_busy_n;

  // Operand decode for the capture cycle
  logic            w_s1;
  logic            w_s2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;

  assign w_s1   = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
  assign w_s2   = w_s1 && (funct3 != 3'd2);
  assign w_neg1 = w_s1 && rs1_val[XLEN-1];
  assign w_neg2 = w_s2 && rs2_val[XLEN-1];
  assign w_mag1 = w_neg1 ? (XLEN'(0) - rs1_val) : rs1_val;
  assign w_mag2 = w_neg2 ? (XLEN'(0) - rs2_val) : rs2_val;
  assign w_div0 = funct3[2] && (rs2_val == '0);
  assign w_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                  (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  assign w_special = w_div0 ? (funct3[1] ? rs1_val : '1)
                            : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef FAST_MUL_EN
  // Full-width product of sign-extended operands; low 2*XLEN bits are exact
  logic [2*XLEN-1:0] w_op1_ext;
  logic [2*XLEN-1:0] w_op2_ext;
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;

  assign w_op1_ext   = {{XLEN{w_neg1}}, rs1_val};
  assign w_op2_ext   = {{XLEN{w_neg2}}, rs2_val};
  assign w_fast_prod = w_op1_ext * w_op2_ext;
  assign w_fast_res  = (funct3[1:0] == 2'd0) ? w_fast_prod[XLEN-1:0]
                                             : w_fast_prod[2*XLEN-1:XLEN];
`endif

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide)
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_sh;
  logic [XLEN:0]   w_div_diff;
  logic [XLEN-1:0] w_it_hi;
  logic [XLEN-1:0] w_it_lo;

  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_a};

  always_comb begin
    if (r_f3[2]) begin
      // Top bit of the difference set means the divisor did not fit
      w_it_hi = w_div_diff[XLEN] ? w_div_sh[XLEN-1:0] : w_div_diff[XLEN-1:0];
      w_it_lo = {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
    end else begin
      w_it_hi = w_mul_sum[XLEN:1];
      w_it_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Signed result from the final iteration's values
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod = r_neg ? ((2*XLEN)'(0) - {w_it_hi, w_it_lo}) : {w_it_hi, w_it_lo};
  assign w_quo  = r_neg ? (XLEN'(0) - w_it_lo) : w_it_lo;
  assign w_rem  = r_rneg ? (XLEN'(0) - w_it_hi) : w_it_hi;

  always_comb begin
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem : w_quo;
    else
      w_final = (r_f3[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_f3_n     = r_f3;
    w_neg_n    = r_neg;
    w_rneg_n   = r_rneg;
    w_a_n      = r_a;
    w_hi_n     = r_hi;
    w_lo_n     = r_lo;
    w_result_n = r_result;
    w_done_n   = r_done;
    w_busy_n   = r_busy;

    if (flush) begin
      w_state_n = S_IDLE;
      w_done_n  = 1'b0;
      w_busy_n  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            w_f3_n   = funct3;
            w_neg_n  = w_neg1 ^ w_neg2;
            w_rneg_n = w_neg1;
            w_hi_n   = '0;
            w_a_n    = funct3[2] ? w_mag2 : w_mag1;
            w_lo_n   = funct3[2] ? w_mag1 : w_mag2;
            if (w_div0 || w_ovf) begin
              w_result_n = w_special;
              w_done_n   = 1'b1;
              w_state_n  = S_DONE;
`ifdef FAST_MUL_EN
            end else if (!funct3[2]) begin
              w_result_n = w_fast_res;
              w_done_n   = 1'b1;
              w_state_n  = S_DONE;
`endif
            end else begin
              w_cnt_n   = '0;
              w_busy_n  = 1'b1;
              w_state_n = S_CALC;
            end
          end
        end
        S_CALC: begin
          w_hi_n  = w_it_hi;
          w_lo_n  = w_it_lo;
          w_cnt_n = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            w_result_n = w_final;
            w_done_n   = 1'b1;
            w_busy_n   = 1'b0;
            w_state_n  = S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            w_done_n  = 1'b0;
            w_state_n = S_IDLE;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b0;
          w_busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_f3     <= w_f3_n;
      r_neg    <= w_neg_n;
      r_rneg   <= w_rneg_n;
      r_a      <= w_a_n;
      r_hi     <= w_hi_n;
      r_lo     <= w_lo_n;
      r_result <= w_result_n;
      r_done   <= w_done_n;
      r_busy   <= w_busy_n;
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;
  assign stall  = req & ~r_done;

endmodule
